// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    localparam logic [XLEN-1:0] PC_INC           = 64'd4;
    localparam logic [ILEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            valid;
    } if_id_t;

    // Clears the byte-offset bits so fetches are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch port: address out from the fetch stage, word back combinationally.
interface fetch_stage_if;

    logic [fetch_pkg::XLEN-1:0] addr;
    logic [fetch_pkg::ILEN-1:0] rdata;

    modport master (output addr, input  rdata);
    modport slave  (input  addr, output rdata);

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect between ID/EX load and IF/ID source registers.
module load_use_detect
    import fetch_pkg::*;
(
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             if_id_valid,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             load_use_c
);

    always_comb begin
        load_use_c = id_ex_memread && (id_ex_rd != '0) && if_id_valid &&
                     ((id_ex_rd == rs1) || (id_ex_rd == rs2));
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, hazard hold and branch redirect.
// Optional cycle counters for STALL/FLUSH are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0,
    parameter logic [ILEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.master    imem,
    input  logic             stall_ext,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [ILEN-1:0]  if_id_inst,
    output logic             if_id_valid,
    output logic             bubble,
    output logic             misalign
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic            misalign_q, misalign_d;
    logic            load_use;
    logic            hold;

    load_use_detect u_load_use_detect (
        .id_ex_memread (id_ex_memread),
        .id_ex_rd      (id_ex_rd),
        .if_id_valid   (if_id_q.valid),
        .rs1           (if_id_q.inst[19:15]),
        .rs2           (if_id_q.inst[24:20]),
        .load_use_c    (load_use)
    );

    assign hold = load_use | stall_ext;

    // Next-state and datapath: redirect beats hold beats normal advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_id_d    = if_id_q;
        misalign_d = misalign_q;
        bubble     = 1'b0;

        if (redirect) begin
            pc_d          = align_pc(redirect_pc);
            if_id_d.pc    = '0;
            if_id_d.inst  = NOP_INST;
            if_id_d.valid = 1'b0;
            misalign_d    = misalign_q | (|redirect_pc[1:0]);
            bubble        = 1'b1;
        end else if (hold) begin
            bubble = load_use;
        end else begin
            pc_d          = pc_q + PC_INC;
            if_id_d.pc    = pc_q;
            if_id_d.inst  = imem.rdata;
            if_id_d.valid = 1'b1;
        end

        unique case (state_q)
            ST_STALL: begin
                if (redirect)   state_d = ST_FLUSH;
                else if (!hold) state_d = ST_RUN;
            end
            default: begin
                if (redirect)  state_d = ST_FLUSH;
                else if (hold) state_d = ST_STALL;
                else           state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_q.pc    <= '0;
            if_id_q.inst  <= NOP_INST;
            if_id_q.valid <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_id_q    <= if_id_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.addr   = pc_q;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_inst  = if_id_q.inst;
    assign if_id_valid = if_id_q.valid;
    assign misalign    = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating residency counters for STALL and FLUSH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == ST_STALL && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (state_q == ST_FLUSH && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
